// File: rtl/maj_net_eval_pkg.sv
// Shared types and width helpers for the majority-network evaluator.
package maj_net_eval_pkg;

  // Widest source index any instance may use; narrower indices are zero-extended.
  localparam int MAX_SW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_DONE
  } state_t;

  // One fanin: source index plus optional inversion.
  typedef struct packed {
    logic              inv;
    logic [MAX_SW-1:0] sel;
  } fanin_t;

  // Source index width: constant 0, the primary inputs, then the nodes.
  function automatic int calc_sw(input int n_in, input int n_nodes);
    return $clog2(1 + n_in + n_nodes);
  endfunction

  // Config address width: node entries plus one output-select entry.
  function automatic int calc_aw(input int n_nodes);
    return $clog2(n_nodes + 1);
  endfunction

  // Node counter width.
  function automatic int calc_kw(input int n_nodes);
    return (n_nodes > 1) ? $clog2(n_nodes) : 1;
  endfunction

endpackage

// File: rtl/maj_fanin_mux.sv
// Selects one source bit by index and optionally inverts it.
// Indices beyond the real source range fall into zero padding and read 0.
module maj_fanin_mux
  import maj_net_eval_pkg::*;
#(
  parameter int N_SRC = 16
) (
  input  logic [N_SRC-1:0] src,
  input  fanin_t           f,
  output logic             val
);

  logic [(1<<MAX_SW)-1:0] src_pad;

  // Zero-pad the source vector so every representable index is safe.
  always_comb begin
    src_pad              = '0;
    src_pad[N_SRC-1:0]   = src;
  end

  assign val = src_pad[f.sel] ^ f.inv;

endmodule

// File: rtl/maj_net_eval.sv
// Sequential evaluator for a configurable network of 3-input majority nodes.
// One node is computed per cycle in index order, so a node only ever sees
// registered values: earlier nodes from this pass, later nodes still cleared.
module maj_net_eval
  import maj_net_eval_pkg::*;
#(
  parameter  int N_IN    = 7,
  parameter  int N_NODES = 8,
  localparam int SW      = calc_sw(N_IN, N_NODES),
  localparam int AW      = calc_aw(N_NODES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [3*(SW+1)-1:0] cfg_data,
  output logic                cfg_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_IN-1:0]     in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_data
);

  localparam int KW    = calc_kw(N_NODES);
  localparam int N_SRC = 1 + N_IN + N_NODES;

  state_t              state_reg;
  logic [KW-1:0]       k_reg;
  logic [N_IN-1:0]     x_reg;
  logic [N_NODES-1:0]  node_reg;

  fanin_t              node_tab [N_NODES][3];
  fanin_t              out_tab;
  fanin_t [2:0]        cfg_field;

  logic [N_SRC-1:0]    src_vec;
  logic [2:0]          fan_val;
  logic                node_val;
  logic                out_val;
  logic                cfg_wr;

  // Source order: index 0 = constant 0, then x, then nodes.
  assign src_vec  = {node_reg, x_reg, 1'b0};
  assign cfg_wr   = cfg_we && (state_reg == ST_IDLE);

  // Unpack the three {inv, sel} fields of a config word, field 0 in the LSBs.
  for (genvar gi = 0; gi < 3; gi++) begin : g_field
    assign cfg_field[gi] = {cfg_data[gi*(SW+1)+SW], MAX_SW'(cfg_data[gi*(SW+1) +: SW])};
  end

  // Three fanin muxes for the node currently being evaluated.
  for (genvar gi = 0; gi < 3; gi++) begin : g_fanin
    maj_fanin_mux #(.N_SRC(N_SRC)) u_mux (
      .src (src_vec),
      .f   (node_tab[k_reg][gi]),
      .val (fan_val[gi])
    );
  end

  assign node_val = (fan_val[0] & fan_val[1]) | (fan_val[0] & fan_val[2]) |
                    (fan_val[1] & fan_val[2]);

  maj_fanin_mux #(.N_SRC(N_SRC)) u_out_mux (
    .src (src_vec),
    .f   (out_tab),
    .val (out_val)
  );

  // Configuration table: cleared on reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N_NODES; n++) begin
        for (int f = 0; f < 3; f++) begin
          node_tab[n][f] <= '0;
        end
      end
      out_tab <= '0;
    end else if (cfg_wr) begin
      if (cfg_addr == AW'(N_NODES)) begin
        out_tab <= cfg_field[0];
      end else if (cfg_addr < AW'(N_NODES)) begin
        for (int f = 0; f < 3; f++) begin
          node_tab[cfg_addr[KW-1:0]][f] <= cfg_field[f];
        end
      end
    end
  end

  // Control FSM: accept a vector, sweep the nodes once, hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      x_reg     <= '0;
      node_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg     <= in_data;
            node_reg  <= '0;
            k_reg     <= '0;
            state_reg <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          node_reg[k_reg] <= node_val;
          k_reg           <= k_reg + KW'(1);
          if (k_reg == KW'(N_NODES - 1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign cfg_ready = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  // Nodes, inputs and table are frozen in DONE, so this is stable while held.
  assign out_data  = (state_reg == ST_DONE) && out_val;

endmodule
